// File: rtl/exec_step_controller_pkg.sv
// Shared definitions for the run/halt/single-step sequencer.
//   exec_state_e        : FSM state encoding, also presented on the debug
//                         state output (HALT=00, RUN=01, STEP=10, BRK=11).
//   DEBOUNCE_CYCLES_DEF : default stable-sample count for the step button
//                         when the STEP_DEBOUNCE_EN build is selected.
package exec_step_controller_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } exec_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/exec_step_controller_step_debouncer.sv
// step_debouncer: turns the asynchronous step pushbutton into a single-cycle
// request pulse.
//   clk_i        : processor clock
//   reset_ni     : synchronous active-low reset
//   step_req_i   : raw pushbutton level (asynchronous)
//   step_pulse_o : one-cycle pulse on each accepted rising edge
// Build option STEP_DEBOUNCE_EN: when defined, the synchronized level must be
// stable for DEBOUNCE_CYCLES consecutive samples before it is accepted; when
// undefined the edge is taken directly from the 2-flop synchronizer.
module step_debouncer
  import exec_step_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic step_req_i,
  output logic step_pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic level_dly_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= step_req_i;
      sync2_q     <= sync1_q;
      level_dly_q <= level;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int unsigned DB_LEN = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W  = (DB_LEN < 2) ? 1 : $clog2(DB_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  // cnt_q counts consecutive samples that differ from the accepted level;
  // the DB_LEN-th differing sample in a row flips the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  // Debounce length is only consumed when the counter is built.
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;

  assign level = sync2_q;
`endif

  assign step_pulse_o = level & ~level_dly_q;

endmodule

// File: rtl/exec_step_controller.sv
// exec_step_controller: run/halt/single-step/breakpoint sequencer producing
// the commit enable of a single-cycle MIPS datapath, plus a retired
// instruction counter.
//   clk      : processor clock (only clock)
//   reset    : synchronous active-low reset
//   run_req  : run switch level (asynchronous)
//   step_req : step pushbutton (asynchronous), rising edge = one instruction
//   bp_en    : breakpoint enable
//   bp_addr  : breakpoint PC (full 32-bit compare)
//   pc       : current PC of the datapath
//   cpu_en   : datapath commit enable
//   halted   : high in HALT and BRK
//   bp_hit   : high in BRK
//   retired  : count of cpu_en cycles, wraps
//   state    : current FSM state for debug display
// Build option STEP_DEBOUNCE_EN adds a debounce counter on the step input.
//
// state | meaning
// HALT  | frozen, waiting for run switch or step press
// RUN   | committing every cycle until switch drops or breakpoint traps
// STEP  | commit exactly one instruction, then HALT
// BRK   | stopped with PC at bp_addr; step executes it, switch low -> HALT
module exec_step_controller
  import exec_step_controller_pkg::*;
#(
  parameter int unsigned COUNT_W         = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        pc,
  output logic               cpu_en,
  output logic               halted,
  output logic               bp_hit,
  output logic [COUNT_W-1:0] retired,
  output logic [1:0]         state
);

  logic               run_s1_q;
  logic               run_s2_q;
  logic               step_pulse;
  exec_state_e        state_q;
  exec_state_e        state_d;
  logic               first_run_q;
  logic               first_run_d;
  logic               halted_q;
  logic               halted_d;
  logic               bp_hit_q;
  logic               bp_hit_d;
  logic [COUNT_W-1:0] retired_q;
  logic [COUNT_W-1:0] retired_d;
  logic               bp_match;
  logic               bp_trap;

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clk_i       (clk),
    .reset_ni    (reset),
    .step_req_i  (step_req),
    .step_pulse_o(step_pulse)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      run_s1_q <= run_req;
      run_s2_q <= run_s1_q;
    end
  end

  assign bp_match = bp_en && (pc == bp_addr);
  // The first RUN cycle ignores the match so resuming from bp_addr
  // does not immediately re-trap on the same instruction.
  assign bp_trap  = bp_match && !first_run_q;

  // Combinational so the breakpoint instruction is never committed.
  assign cpu_en = (state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_trap);

  always_comb begin
    state_d     = state_q;
    first_run_d = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (run_s2_q) begin
          state_d     = ST_RUN;
          first_run_d = 1'b1;
        end else if (step_pulse) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!run_s2_q) begin
          state_d = ST_HALT;
        end else if (bp_trap) begin
          state_d = ST_BRK;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      ST_BRK: begin
        if (step_pulse) begin
          state_d = ST_STEP;
        end else if (!run_s2_q) begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    halted_d  = (state_d == ST_HALT) || (state_d == ST_BRK);
    bp_hit_d  = (state_d == ST_BRK);
    retired_d = cpu_en ? retired_q + COUNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_HALT;
      first_run_q <= 1'b0;
      halted_q    <= 1'b1;
      bp_hit_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      first_run_q <= first_run_d;
      halted_q    <= halted_d;
      bp_hit_q    <= bp_hit_d;
      retired_q   <= retired_d;
    end
  end

  assign halted  = halted_q;
  assign bp_hit  = bp_hit_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_exec_step_controller.sv
module tb_exec_step_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_req = 1'b0;
  logic        step_req = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        cpu_en, halted, bp_hit;
  logic [15:0] retired;
  logic [1:0]  state;
  logic        cpu_en4, halted4, bp_hit4;
  logic [3:0]  retired4;
  logic [1:0]  state4;

  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'h0;

  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] model_pc = 32'h0;
  logic [31:0] model_commits = 32'h0;
  logic [31:0] mon_commits = 32'h0;

  exec_step_controller #(.COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
    .halted(halted), .bp_hit(bp_hit), .retired(retired), .state(state)
  );

  exec_step_controller #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en4),
    .halted(halted4), .bp_hit(bp_hit4), .retired(retired4), .state(state4)
  );

  always #5 clk = ~clk;

  // Datapath PC stand-in: advances only on committed cycles.
  always @(posedge clk) begin
    if (!reset) pc <= 32'h0;
    else if (pc_load) pc <= pc_load_val;
    else if (cpu_en) pc <= pc + 32'h1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every commit cycle pops the next expected PC.
  always @(negedge clk) begin
    if (cpu_en) begin
      if (exp_pc_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_commit: got commit of pc 0x%0h expected none at %0t", pc, $time);
      end else begin
        check("commit_pc", pc, exp_pc_q.pop_front());
      end
      check("commit_retired", retired, mon_commits[15:0]);
      check("commit_retired4", retired4, mon_commits[3:0]);
      check("commit_en4", cpu_en4, 1);
      mon_commits = mon_commits + 1;
    end
    if (!reset) mon_commits = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_commit();
    exp_pc_q.push_back(model_pc);
    model_pc = model_pc + 1;
    model_commits = model_commits + 1;
  endtask

  task automatic quiesce(input string tag);
    check({tag, "_state"}, state, 2'b00);
    check({tag, "_halted"}, halted, 1);
    check({tag, "_bp_hit"}, bp_hit, 0);
    check({tag, "_cpu_en"}, cpu_en, 0);
    check({tag, "_retired"}, retired, model_commits[15:0]);
    check({tag, "_retired4"}, retired4, model_commits[3:0]);
    check({tag, "_pending"}, exp_pc_q.size(), 0);
  endtask

  task automatic do_step(input int hold);
    expect_commit();
    step_req = 1'b1;
    settle(hold);
    step_req = 1'b0;
    settle(6);
  endtask

  // Run for k sampled cycles; expectation built by walking the PC sequence.
  task automatic do_run(input int k, input bit use_bp, input int d, input bit flip, input bit inject);
    int j;
    bp_en   = use_bp;
    bp_addr = (model_pc + 32'(d)) ^ (flip ? 32'h8000_0000 : 32'h0);
    for (int i = 0; i < k; i++) begin
      if (i > 0 && bp_en && model_pc == bp_addr) break;
      expect_commit();
    end
    j = (k >= 3) ? int'($urandom_range(1, k - 2)) : 0;
    run_req = 1'b1;
    for (int t = 1; t <= k; t++) begin
      tick();
      if (inject && t == j) step_req = 1'b1;
      if (t == j + 2) step_req = 1'b0;
    end
    run_req  = 1'b0;
    step_req = 1'b0;
    settle(6);
  endtask

  initial begin
    logic [3:0] wrap_exp [3];
    wrap_exp[0] = 4'd15;
    wrap_exp[1] = 4'd0;
    wrap_exp[2] = 4'd1;

    reset = 1'b0;
    settle(3);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_cpu_en", cpu_en, 0);
      check("rst_halted", halted, 1);
      check("rst_retired", retired, 0);
      check("rst_state", state, 2'b00);
    end

    // Single step latency: high for exactly the cycle after E2.
    expect_commit();
    step_req = 1'b1;
    tick(); check("step_e0", cpu_en, 0);
    tick(); check("step_e1", cpu_en, 0);
    tick(); check("step_e2", cpu_en, 1); check("step_state", state, 2'b10);
    tick(); check("step_e3", cpu_en, 0); check("step_back", state, 2'b00);
    step_req = 1'b0;
    settle(4);
    quiesce("step1");

    // Breakpoint at 5 from PC 0 (restart from reset for a clean PC).
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    model_pc = 0; model_commits = 0;
    settle(2);
    bp_en = 1'b1; bp_addr = 32'h5;
    for (int i = 0; i < 5; i++) expect_commit();
    run_req = 1'b1;
    settle(10);
    check("bp_state", state, 2'b11);
    check("bp_hit", bp_hit, 1);
    check("bp_halted", halted, 1);
    check("bp_cpu_en", cpu_en, 0);
    check("bp_retired", retired, 5);
    expect_commit();
    step_req = 1'b1; run_req = 1'b0;
    settle(3);
    step_req = 1'b0;
    settle(6);
    quiesce("bp_step");
    check("bp_step_retired", retired, 6);

    // Run rising together with a step edge: RUN wins, no STEP cycle.
    bp_en = 1'b0;
    for (int i = 0; i < 8; i++) expect_commit();
    step_req = 1'b1; run_req = 1'b1;
    settle(3);
    check("coinc_state", state, 2'b01);
    settle(5);
    run_req = 1'b0; step_req = 1'b0;
    settle(6);
    quiesce("coinc");

    // Reset asserted mid-RUN after 100 enabled cycles.
    for (int i = 0; i < 100; i++) expect_commit();
    run_req = 1'b1;
    settle(102);
    reset = 1'b0; run_req = 1'b0;
    tick();
    check("rstrun_cpu_en", cpu_en, 0);
    check("rstrun_retired", retired, 0);
    check("rstrun_retired4", retired4, 0);
    check("rstrun_state", state, 2'b00);
    model_pc = 0; model_commits = 0;
    tick();
    reset = 1'b1;
    settle(3);
    quiesce("rstrun");

    // 17 steps: the 4-bit counter wraps 15 -> 0 -> 1.
    for (int i = 1; i <= 17; i++) begin
      do_step(2);
      if (i >= 15) check("wrap4", retired4, wrap_exp[i-15]);
    end
    quiesce("wrap");

    // Randomized operations against the PC-walk model.
    for (int n = 0; n < 60; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          bp_en = 1'($urandom);
          bp_addr = model_pc;
          do_step(int'($urandom_range(1, 4)));
        end
        1: begin
          int k;
          bit ub;
          k  = int'($urandom_range(3, 20));
          ub = 1'($urandom);
          do_run(k, ub, int'($urandom_range(0, k + 2)), ($urandom_range(0, 3) == 0),
                 !ub && 1'($urandom));
        end
        2: begin
          pc_load_val = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                    : $urandom;
          pc_load = 1'b1;
          tick();
          pc_load = 1'b0;
          model_pc = pc_load_val;
          settle(1);
        end
        default: settle(int'($urandom_range(1, 5)));
      endcase
      quiesce("rand");
    end

    settle(5);
    check("final_pending", exp_pc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
